// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
// LIFO stack of DEPTH words, each WIDTH bits wide. Commands are sampled on the
// rising edge of clk and every output is registered, so there is one cycle of
// latency and no combinational path from inputs to outputs.
//
// Ports
//   clk   : in  1      single clock, all state moves on the rising edge
//   rst   : in  1      synchronous active-high reset (count, dout, err cleared)
//   PUSH  : in  1      push din onto the stack
//   POP   : in  1      remove the top word and present it on dout
//   TOS   : in  1      present the top word on dout without removing it
//   din   : in  WIDTH  write data
//   dout  : out WIDTH  registered read data
//   count : out CW     number of stored words, 0..DEPTH
//   empty : out 1      count == 0
//   full  : out 1      count == DEPTH
//   err   : out 1      one-cycle pulse flagging an illegal request
//
// Command priority: PUSH+POP is a replace of the top word; POP masks TOS;
// PUSH alone masks TOS and leaves dout untouched.
// -----------------------------------------------------------------------------
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             TOS,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    // Address width of the storage array; DEPTH >= 2 keeps this at least 1.
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] dout_r;
    logic             err_r;
    logic             empty_r;
    logic             full_r;

    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] dout_next_s;
    logic             err_next_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [CW-1:0]    count_m1_s;
    logic [AW-1:0]    top_idx_s;
    logic [WIDTH-1:0] top_word_s;

    // Next free slot sits at index count; the current top word at count-1.
    // When the stack is full the free-slot index aliases but is never written.
    assign count_m1_s = count_r - ONE_C;
    assign top_idx_s  = count_m1_s[AW-1:0];
    assign top_word_s = mem_r[top_idx_s];

    // Command decode: next count/dout/err and the array write request.
    always_comb begin
        count_next_s = count_r;
        dout_next_s  = dout_r;
        err_next_s   = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = count_r[AW-1:0];

        case ({PUSH, POP})
            2'b11: begin
                if (empty_r) begin
                    // Nothing to pop: the push still lands in slot 0.
                    wr_en_s      = 1'b1;
                    wr_idx_s     = count_r[AW-1:0];
                    count_next_s = ONE_C;
                    err_next_s   = 1'b1;
                end else begin
                    // Replace: old top goes out, din takes its slot; legal even when full.
                    wr_en_s     = 1'b1;
                    wr_idx_s    = top_idx_s;
                    dout_next_s = top_word_s;
                end
            end
            2'b10: begin
                if (full_r) begin
                    err_next_s = 1'b1;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_idx_s     = count_r[AW-1:0];
                    count_next_s = count_r + ONE_C;
                end
            end
            2'b01: begin
                if (empty_r) begin
                    err_next_s = 1'b1;
                end else begin
                    dout_next_s  = top_word_s;
                    count_next_s = count_m1_s;
                end
            end
            2'b00: begin
                if (TOS) begin
                    if (empty_r) begin
                        err_next_s = 1'b1;
                    end else begin
                        dout_next_s = top_word_s;
                    end
                end else begin
                    err_next_s = 1'b0;
                end
            end
            default: begin
                err_next_s = 1'b0;
            end
        endcase
    end

    // Control and output registers; empty/full are registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO_C;
            dout_r  <= {WIDTH{1'b0}};
            err_r   <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            dout_r  <= dout_next_s;
            err_r   <= err_next_s;
            empty_r <= (count_next_s == ZERO_C);
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Storage array: not cleared by reset, stale words are hidden behind count.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    assign dout  = dout_r;
    assign count = count_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign err   = err_r;

endmodule

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
// Self-checking bench for param_stack (WIDTH=8, DEPTH=4). Directed scenarios
// check against fixed constants; a randomized run checks against a queue-based
// stack model kept here.
// -----------------------------------------------------------------------------
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;

    int checks;
    int fails;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_err;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .PUSH (push),
        .POP  (pop),
        .TOS  (tos),
        .din  (din),
        .dout (dout),
        .count(count),
        .empty(empty),
        .full (full),
        .err  (err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one command for one edge, advance the stack model, sample #1 later.
    task automatic cycle(input logic r, input logic p, input logic o,
                         input logic t, input logic [WIDTH-1:0] d);
        rst  = r;
        push = p;
        pop  = o;
        tos  = t;
        din  = d;
        m_err = 1'b0;
        if (r) begin
            q.delete();
            m_dout = '0;
        end else if (p && o) begin
            if (q.size() == 0) begin
                q.push_back(d);
                m_err = 1'b1;
            end else begin
                m_dout = q[q.size() - 1];
                q[q.size() - 1] = d;
            end
        end else if (p) begin
            if (q.size() == DEPTH) m_err = 1'b1;
            else q.push_back(d);
        end else if (o) begin
            if (q.size() == 0) m_err = 1'b1;
            else m_dout = q.pop_back();
        end else if (t) begin
            if (q.size() == 0) m_err = 1'b1;
            else m_dout = q[q.size() - 1];
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b dout=%h err=%b, required count=0 empty=1 full=0 dout=00 err=0",
                     count, empty, full, dout, err);
        end
    endtask

    task automatic test_tos();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h30);
        checks++;
        if (count !== 3'd2 || dout !== 8'h00) begin
            fails++;
            $display("FAIL push_holds_dout: count=%0d dout=%h, required count=2 dout=00", count, dout);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (count !== 3'd2 || dout !== 8'h30 || err !== 1'b0) begin
            fails++;
            $display("FAIL tos_first: count=%0d dout=%h err=%b, required count=2 dout=30 err=0", count, dout, err);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (count !== 3'd2 || dout !== 8'h30) begin
            fails++;
            $display("FAIL tos_second: count=%0d dout=%h, required count=2 dout=30", count, dout);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [WIDTH-1:0] exp_d;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, WIDTH'(i));
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
            fails++;
            $display("FAIL fill: full=%b count=%0d empty=%b, required full=1 count=4 empty=0", full, count, empty);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        checks++;
        if (err !== 1'b1 || count !== 3'd4) begin
            fails++;
            $display("FAIL overflow: err=%b count=%0d, required err=1 count=4", err, count);
        end
        for (int i = 4; i >= 1; i--) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            exp_d = WIDTH'(i);
            checks++;
            if (dout !== exp_d || err !== 1'b0 || count !== CW'(i - 1)) begin
                fails++;
                $display("FAIL drain_pop: dout=%h err=%b count=%0d, required dout=%h err=0 count=%0d",
                         dout, err, count, exp_d, i - 1);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL drained: empty=%b full=%b, required empty=1 full=0", empty, full);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (err !== 1'b1 || dout !== 8'h01 || count !== 3'd0) begin
            fails++;
            $display("FAIL underflow_pop: err=%b dout=%h count=%0d, required err=1 dout=01 count=0", err, dout, count);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (err !== 1'b1 || dout !== 8'h01 || count !== 3'd0) begin
            fails++;
            $display("FAIL underflow_tos: err=%b dout=%h count=%0d, required err=1 dout=01 count=0", err, dout, count);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse_width: err=%b, required 0", err);
        end
    endtask

    task automatic test_replace();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
        checks++;
        if (dout !== 8'h22 || count !== 3'd2 || err !== 1'b0) begin
            fails++;
            $display("FAIL replace: dout=%h count=%0d err=%b, required dout=22 count=2 err=0", dout, count, err);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dout !== 8'hAA || count !== 3'd1) begin
            fails++;
            $display("FAIL replace_pop: dout=%h count=%0d, required dout=aa count=1", dout, count);
        end
        // Replace while full must not count as overflow
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h66);
        checks++;
        if (dout !== 8'h55 || count !== 3'd4 || err !== 1'b0 || full !== 1'b1) begin
            fails++;
            $display("FAIL replace_full: dout=%h count=%0d err=%b full=%b, required dout=55 count=4 err=0 full=1",
                     dout, count, err, full);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (dout !== 8'h66) begin
            fails++;
            $display("FAIL replace_full_tos: dout=%h, required 66", dout);
        end
        // Replace on an empty stack: push happens, error flagged
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        checks++;
        if (count !== 3'd1 || err !== 1'b1 || dout !== 8'h00) begin
            fails++;
            $display("FAIL replace_empty: count=%0d err=%b dout=%h, required count=1 err=1 dout=00", count, err, dout);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (dout !== 8'h55 || err !== 1'b0) begin
            fails++;
            $display("FAIL replace_empty_tos: dout=%h err=%b, required dout=55 err=0", dout, err);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hA3);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || dout !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: count=%0d empty=%b dout=%h err=%b, required count=0 empty=1 dout=00 err=0",
                     count, empty, dout, err);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (err !== 1'b1 || count !== 3'd0 || dout !== 8'h00) begin
            fails++;
            $display("FAIL pop_after_reset: err=%b count=%0d dout=%h, required err=1 count=0 dout=00", err, count, dout);
        end
    endtask

    task automatic test_random();
        logic          r, p, o, t;
        logic [CW-1:0] exp_cnt;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            p = ($urandom_range(0, 99) < 45);
            o = ($urandom_range(0, 99) < 40);
            t = ($urandom_range(0, 99) < 30);
            cycle(r, p, o, t, WIDTH'($urandom));
            exp_cnt = CW'(q.size());
            checks++;
            if (count !== exp_cnt || dout !== m_dout || err !== m_err ||
                empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
                fails++;
                $display("FAIL random_step %0d: count=%0d dout=%h err=%b empty=%b full=%b, required count=%0d dout=%h err=%b empty=%b full=%b",
                         i, count, dout, err, empty, full, exp_cnt, m_dout, m_err,
                         (q.size() == 0), (q.size() == DEPTH));
            end
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        tos    = 1'b0;
        din    = '0;
        m_dout = '0;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_tos();
        test_overflow_underflow();
        test_replace();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal values 1 and above).
REQ-002 Parameter DEPTH, default 16, maximum number of stored words (legal values 2 and above).
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the count output (derived; not overridden).
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on the rising edge only.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port PUSH, input, 1, request to push din onto the stack.
REQ-007 Port POP, input, 1, request to remove the top word and present it on dout.
REQ-008 Port TOS, input, 1, request to present the top word on dout without removing it.
REQ-009 Port din, input, WIDTH, write data.
REQ-010 Port dout, output, WIDTH, registered read data.
REQ-011 Port count, output, CW, number of stored words (0..DEPTH).
REQ-012 Port empty, output, 1, high when count is 0.
REQ-013 Port full, output, 1, high when count is DEPTH.
REQ-014 Port err, output, 1, one-cycle registered pulse that flags an illegal request.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH register array indexed by count; the top word is at index count-1.
REQ-016 Commands SHALL be sampled at the rising edge; count, empty, full, dout and err SHALL reflect that edge immediately after it (one-cycle latency, no combinational input-to-output path).
REQ-017 PUSH alone with full=0: mem[count] <= din, count +1, dout unchanged.
REQ-018 PUSH alone with full=1 (overflow): no write, count unchanged, err=1 for one cycle.
REQ-019 POP alone with empty=0: dout <= top word, count -1.
REQ-020 POP alone with empty=1 (underflow): dout unchanged, count unchanged, err=1 for one cycle.
REQ-021 TOS with no PUSH/POP and empty=0: dout <= top word; count unchanged.
REQ-022 TOS with empty=1: dout unchanged, err=1 for one cycle.
REQ-023 PUSH and POP together with empty=0 (replace): dout <= old top word, top word overwritten with din, count unchanged, err=0; this SHALL also apply when full=1.
REQ-024 PUSH and POP together with empty=1: push proceeds per REQ-017, pop ignored, err=1 for one cycle.
REQ-025 When POP is asserted, TOS SHALL be ignored; when PUSH alone is asserted, TOS SHALL be ignored and dout SHALL hold.
REQ-026 err SHALL be 0 in any cycle whose sampled commands are legal or idle.
REQ-027 empty and full SHALL be decoded from the registered count and SHALL never both be 1.
REQ-028 count SHALL never wrap: it stays in 0..DEPTH under any input sequence.

Reset
REQ-029 On a rising edge with rst=1, the block SHALL set count=0, dout=0 and err=0 (so empty=1, full=0), ignoring PUSH, POP and TOS on that edge.
REQ-030 Array contents SHALL NOT be cleared by reset; they SHALL be unobservable until rewritten.
REQ-031 Reset asserted in the middle of any sequence SHALL take effect at the next edge and discard all stored words.

Verification
REQ-032 Reset, then PUSH 0x3C, PUSH 0x30, then TOS -> count=2, dout=0x30, err=0; a second TOS keeps count at 2.
REQ-033 With DEPTH=4: push 0x01..0x04 -> full=1, count=4; PUSH 0x05 -> err pulse, count=4; then four POPs -> dout=0x04,0x03,0x02,0x01, empty=1.
REQ-034 From empty: POP -> err=1 for one cycle, dout unchanged, count=0; TOS -> same.
REQ-035 Stack holding [0x11,0x22] (top 0x22): PUSH+POP with din=0xAA -> dout=0x22, count=2; then POP -> dout=0xAA.
REQ-036 From empty: PUSH+POP with din=0x55 -> count=1, err=1; then TOS -> dout=0x55.
REQ-037 Three words pushed, rst high for one edge together with PUSH -> count=0, empty=1, dout=0, err=0; then POP -> err=1.
